// File: rtl/tl_bank_binder_q.sv
// TileLink-UL bank binder: buffers the A and D channels, limits outstanding requests
// by TL message (beat-aware), and decodes a bank select from the queued A address.

module tl_bbq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    enq, deq;

    assign in_ready  = (cnt_q != FULL);
    assign out_valid = (cnt_q != '0);
    assign out_data  = mem_q[rptr_q];
    assign enq       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (enq) begin
            mem_d[wptr_q] = in_data;
            wptr_d        = wptr_q + 1'b1;  // power-of-two depth wraps naturally
        end
        if (deq) rptr_d = rptr_q + 1'b1;
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

module tl_bank_binder_q #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int SRC_W        = 2,
    parameter int SIZE_W       = 3,
    parameter int USER_W       = 7,
    parameter int A_DEPTH      = 2,
    parameter int D_DEPTH      = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int BANK_SHIFT   = 6,
    parameter int BANK_BITS    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 auto_in_a_valid,
    output logic                 auto_in_a_ready,
    input  logic [2:0]           auto_in_a_bits_opcode,
    input  logic [2:0]           auto_in_a_bits_param,
    input  logic [SIZE_W-1:0]    auto_in_a_bits_size,
    input  logic [SRC_W-1:0]     auto_in_a_bits_source,
    input  logic [ADDR_W-1:0]    auto_in_a_bits_address,
    input  logic [USER_W-1:0]    auto_in_a_bits_user,
    input  logic [DATA_W/8-1:0]  auto_in_a_bits_mask,
    input  logic [DATA_W-1:0]    auto_in_a_bits_data,
    input  logic                 auto_in_a_bits_corrupt,
    output logic                 auto_out_a_valid,
    input  logic                 auto_out_a_ready,
    output logic [2:0]           auto_out_a_bits_opcode,
    output logic [2:0]           auto_out_a_bits_param,
    output logic [SIZE_W-1:0]    auto_out_a_bits_size,
    output logic [SRC_W-1:0]     auto_out_a_bits_source,
    output logic [ADDR_W-1:0]    auto_out_a_bits_address,
    output logic [USER_W-1:0]    auto_out_a_bits_user,
    output logic [DATA_W/8-1:0]  auto_out_a_bits_mask,
    output logic [DATA_W-1:0]    auto_out_a_bits_data,
    output logic                 auto_out_a_bits_corrupt,
    output logic [BANK_BITS-1:0] auto_out_a_bank,
    input  logic                 auto_out_d_valid,
    output logic                 auto_out_d_ready,
    input  logic [2:0]           auto_out_d_bits_opcode,
    input  logic [SIZE_W-1:0]    auto_out_d_bits_size,
    input  logic [SRC_W-1:0]     auto_out_d_bits_source,
    input  logic                 auto_out_d_bits_denied,
    input  logic [DATA_W-1:0]    auto_out_d_bits_data,
    input  logic                 auto_out_d_bits_corrupt,
    output logic                 auto_in_d_valid,
    input  logic                 auto_in_d_ready,
    output logic [2:0]           auto_in_d_bits_opcode,
    output logic [SIZE_W-1:0]    auto_in_d_bits_size,
    output logic [SRC_W-1:0]     auto_in_d_bits_source,
    output logic                 auto_in_d_bits_denied,
    output logic [DATA_W-1:0]    auto_in_d_bits_data,
    output logic                 auto_in_d_bits_corrupt,
    output logic [7:0]           inflight,
    output logic                 err_underflow
);
    localparam int LG = $clog2(DATA_W / 8);
    localparam int BW = 1 << SIZE_W;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [SIZE_W-1:0]   size;
        logic [SRC_W-1:0]    source;
        logic [ADDR_W-1:0]   address;
        logic [USER_W-1:0]   user;
        logic [DATA_W/8-1:0] mask;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } a_pay_t;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [SIZE_W-1:0] size;
        logic [SRC_W-1:0]  source;
        logic              denied;
        logic [DATA_W-1:0] data;
        logic              corrupt;
    } d_pay_t;

    // Index of the final beat of a data-carrying message of the given size.
    function automatic logic [BW-1:0] beats_m1(input logic [SIZE_W-1:0] sz);
        int s;
        s = int'(sz);
        if (s <= LG) return '0;
        return BW'((1 << (s - LG)) - 1);
    endfunction

    a_pay_t        a_in, a_out;
    d_pay_t        d_in, d_out;
    logic          a_fifo_rdy, a_lim_ok, a_first, a_last, in_a_fire;
    logic          d_last, in_d_fire, inc, dec;
    logic [BW-1:0] a_beat_q, a_beat_d, d_beat_q, d_beat_d;
    logic [7:0]    inflight_q, inflight_d;
    logic          err_q, err_d;

    assign a_in = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                   auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_user,
                   auto_in_a_bits_mask, auto_in_a_bits_data, auto_in_a_bits_corrupt};
    assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
            auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_user,
            auto_out_a_bits_mask, auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_out;
    assign auto_out_a_bank = a_out.address[BANK_SHIFT +: BANK_BITS];

    assign d_in = {auto_out_d_bits_opcode, auto_out_d_bits_size, auto_out_d_bits_source,
                   auto_out_d_bits_denied, auto_out_d_bits_data, auto_out_d_bits_corrupt};
    assign {auto_in_d_bits_opcode, auto_in_d_bits_size, auto_in_d_bits_source,
            auto_in_d_bits_denied, auto_in_d_bits_data, auto_in_d_bits_corrupt} = d_out;

    // Only the first beat of a message opens a new outstanding slot.
    assign a_first         = (a_beat_q == '0);
    assign a_last          = a_in.opcode[2] | (a_beat_q == beats_m1(a_in.size));
    assign a_lim_ok        = ~a_first | (inflight_q < 8'(MAX_INFLIGHT));
    assign auto_in_a_ready = a_fifo_rdy & a_lim_ok;
    assign in_a_fire       = auto_in_a_valid & auto_in_a_ready;

    assign d_last    = ~d_out.opcode[0] | (d_beat_q == beats_m1(d_out.size));
    assign in_d_fire = auto_in_d_valid & auto_in_d_ready;

    tl_bbq_fifo #(.W($bits(a_pay_t)), .DEPTH(A_DEPTH)) u_a_fifo (
        .clock(clock), .reset(reset),
        .in_valid(auto_in_a_valid & a_lim_ok), .in_ready(a_fifo_rdy), .in_data(a_in),
        .out_valid(auto_out_a_valid), .out_ready(auto_out_a_ready), .out_data(a_out)
    );

    tl_bbq_fifo #(.W($bits(d_pay_t)), .DEPTH(D_DEPTH)) u_d_fifo (
        .clock(clock), .reset(reset),
        .in_valid(auto_out_d_valid), .in_ready(auto_out_d_ready), .in_data(d_in),
        .out_valid(auto_in_d_valid), .out_ready(auto_in_d_ready), .out_data(d_out)
    );

    always_comb begin
        a_beat_d   = a_beat_q;
        d_beat_d   = d_beat_q;
        inflight_d = inflight_q;
        err_d      = err_q;
        inc        = in_a_fire & a_first;
        dec        = in_d_fire & d_last;
        if (in_a_fire) a_beat_d = a_last ? '0 : a_beat_q + 1'b1;
        if (in_d_fire) d_beat_d = d_last ? '0 : d_beat_q + 1'b1;
        if (inc && !dec) begin
            inflight_d = inflight_q + 8'd1;
        end else if (dec && !inc) begin
            if (inflight_q == 8'd0) err_d = 1'b1;
            else                    inflight_d = inflight_q - 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_beat_q   <= '0;
            d_beat_q   <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            a_beat_q   <= a_beat_d;
            d_beat_q   <= d_beat_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign inflight      = inflight_q;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_tl_bank_binder_q.sv
// Scoreboard bench for tl_bank_binder_q: queue-based transactors, message-level model
// of the outstanding count, randomized traffic plus directed corner cases.

module tb_tl_bank_binder_q;
    localparam int DATA_W = 32, ADDR_W = 32, SRC_W = 2, SIZE_W = 3, USER_W = 7;
    localparam int MAX_INF = 4, BANK_SHIFT = 6, BANK_BITS = 2;

    typedef struct packed {
        logic [2:0] opcode; logic [2:0] param; logic [SIZE_W-1:0] size;
        logic [SRC_W-1:0] source; logic [ADDR_W-1:0] address; logic [USER_W-1:0] user;
        logic [DATA_W/8-1:0] mask; logic [DATA_W-1:0] data; logic corrupt;
    } a_t;
    typedef struct packed {
        logic [2:0] opcode; logic [SIZE_W-1:0] size; logic [SRC_W-1:0] source;
        logic denied; logic [DATA_W-1:0] data; logic corrupt;
    } d_t;
    typedef struct { a_t p; bit first; bit last; } a_item_t;
    typedef struct { d_t p; bit last; } d_item_t;

    logic clock = 0, reset = 1;
    always #5 clock = ~clock;

    logic auto_in_a_valid, auto_in_a_ready, auto_out_a_valid, auto_out_a_ready;
    logic auto_out_d_valid, auto_out_d_ready, auto_in_d_valid, auto_in_d_ready;
    a_t   ia, oa;
    d_t   od, id;
    logic [BANK_BITS-1:0] auto_out_a_bank;
    logic [7:0] inflight;
    logic err_underflow;

    tl_bank_binder_q #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRC_W(SRC_W), .SIZE_W(SIZE_W),
        .USER_W(USER_W), .A_DEPTH(2), .D_DEPTH(2), .MAX_INFLIGHT(MAX_INF),
        .BANK_SHIFT(BANK_SHIFT), .BANK_BITS(BANK_BITS)) dut (
        .clock(clock), .reset(reset),
        .auto_in_a_valid(auto_in_a_valid), .auto_in_a_ready(auto_in_a_ready),
        .auto_in_a_bits_opcode(ia.opcode), .auto_in_a_bits_param(ia.param),
        .auto_in_a_bits_size(ia.size), .auto_in_a_bits_source(ia.source),
        .auto_in_a_bits_address(ia.address), .auto_in_a_bits_user(ia.user),
        .auto_in_a_bits_mask(ia.mask), .auto_in_a_bits_data(ia.data),
        .auto_in_a_bits_corrupt(ia.corrupt),
        .auto_out_a_valid(auto_out_a_valid), .auto_out_a_ready(auto_out_a_ready),
        .auto_out_a_bits_opcode(oa.opcode), .auto_out_a_bits_param(oa.param),
        .auto_out_a_bits_size(oa.size), .auto_out_a_bits_source(oa.source),
        .auto_out_a_bits_address(oa.address), .auto_out_a_bits_user(oa.user),
        .auto_out_a_bits_mask(oa.mask), .auto_out_a_bits_data(oa.data),
        .auto_out_a_bits_corrupt(oa.corrupt), .auto_out_a_bank(auto_out_a_bank),
        .auto_out_d_valid(auto_out_d_valid), .auto_out_d_ready(auto_out_d_ready),
        .auto_out_d_bits_opcode(od.opcode), .auto_out_d_bits_size(od.size),
        .auto_out_d_bits_source(od.source), .auto_out_d_bits_denied(od.denied),
        .auto_out_d_bits_data(od.data), .auto_out_d_bits_corrupt(od.corrupt),
        .auto_in_d_valid(auto_in_d_valid), .auto_in_d_ready(auto_in_d_ready),
        .auto_in_d_bits_opcode(id.opcode), .auto_in_d_bits_size(id.size),
        .auto_in_d_bits_source(id.source), .auto_in_d_bits_denied(id.denied),
        .auto_in_d_bits_data(id.data), .auto_in_d_bits_corrupt(id.corrupt),
        .inflight(inflight), .err_underflow(err_underflow)
    );

    a_item_t a_stim[$], a_exp[$];
    d_item_t d_stim[$], d_exp[$], d_hold[$];
    int  checks = 0, errors = 0;
    int  m_inflight = 0, a_accepted = 0;
    bit  m_err = 0, chk_en = 0, gaps = 0, hold_resp = 0, fixed_en = 0;
    int  oa_mode = 2, id_mode = 2;
    logic [DATA_W-1:0] fixed_data = '0, last_id_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int nbeats(input int size);
        int b;
        b = (1 << size) / (DATA_W / 8);
        return (b < 1) ? 1 : b;
    endfunction

    // Queue one TL message; Puts carry nbeats(size) data beats, Gets are single-beat.
    task automatic push_msg(input logic [2:0] op, input int size, input logic [SRC_W-1:0] src,
                            input logic [ADDR_W-1:0] addr);
        a_item_t it;
        int n;
        n = op[2] ? 1 : nbeats(size);
        for (int i = 0; i < n; i++) begin
            it.p = '{opcode: op, param: 3'($urandom), size: SIZE_W'(size), source: src,
                     address: addr, user: USER_W'($urandom), mask: 4'($urandom),
                     data: $urandom, corrupt: 1'($urandom)};
            it.first = (i == 0);
            it.last  = (i == n - 1);
            a_stim.push_back(it);
        end
    endtask

    task automatic gen_resp(input a_t req);
        d_item_t r;
        int n;
        n = req.opcode[2] ? nbeats(int'(req.size)) : 1;
        for (int i = 0; i < n; i++) begin
            r.p = '{opcode: req.opcode[2] ? 3'd1 : 3'd0, size: req.size, source: req.source,
                    denied: 1'($urandom), data: fixed_en ? fixed_data : $urandom,
                    corrupt: 1'($urandom)};
            r.last = (i == n - 1);
            if (hold_resp) d_hold.push_back(r);
            else           d_stim.push_back(r);
        end
    endtask

    // Upstream A driver: valid is held until the beat is accepted.
    initial begin
        bit fired;
        a_item_t it;
        auto_in_a_valid = 0; ia = '0;
        forever begin
            @(negedge clock);
            fired = 0;
            if (!reset && auto_in_a_valid && auto_in_a_ready) begin
                it = a_stim.pop_front();
                a_exp.push_back(it);
                a_accepted++;
                if (it.first) m_inflight++;
                fired = 1;
            end
            @(posedge clock); #1;
            if (!(auto_in_a_valid && !fired)) begin
                if (a_stim.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
                    auto_in_a_valid = 1; ia = a_stim[0].p;
                end else auto_in_a_valid = 0;
            end
        end
    end

    // Downstream A monitor/responder.
    initial begin
        a_item_t ea;
        auto_out_a_ready = 0;
        forever begin
            @(negedge clock);
            if (!reset && auto_out_a_valid && auto_out_a_ready) begin
                checks++;
                if (a_exp.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected actual=%h required=none", oa);
                end else begin
                    ea = a_exp.pop_front();
                    if (oa !== ea.p) begin
                        errors++;
                        $display("FAIL a_payload actual=%h required=%h", oa, ea.p);
                    end
                    chk("a_bank", 64'(auto_out_a_bank), 64'(ea.p.address[BANK_SHIFT +: BANK_BITS]));
                    if (ea.last) gen_resp(ea.p);
                end
            end
            @(posedge clock); #1;
            auto_out_a_ready = (oa_mode == 2) || (oa_mode == 1 && $urandom_range(1) == 1);
        end
    end

    // Downstream D driver.
    initial begin
        bit fired;
        auto_out_d_valid = 0; od = '0;
        forever begin
            @(negedge clock);
            fired = 0;
            if (!reset && auto_out_d_valid && auto_out_d_ready) begin
                d_exp.push_back(d_stim.pop_front());
                fired = 1;
            end
            @(posedge clock); #1;
            if (!(auto_out_d_valid && !fired)) begin
                if (d_stim.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
                    auto_out_d_valid = 1; od = d_stim[0].p;
                end else auto_out_d_valid = 0;
            end
        end
    end

    // Upstream D monitor: message completion retires one outstanding request.
    initial begin
        d_item_t ed;
        auto_in_d_ready = 0;
        forever begin
            @(negedge clock);
            if (!reset && auto_in_d_valid && auto_in_d_ready) begin
                checks++;
                last_id_data = id.data;
                if (d_exp.size() == 0) begin
                    errors++;
                    $display("FAIL d_unexpected actual=%h required=none", id);
                end else begin
                    ed = d_exp.pop_front();
                    if (id !== ed.p) begin
                        errors++;
                        $display("FAIL d_payload actual=%h required=%h", id, ed.p);
                    end
                    if (ed.last) begin
                        if (m_inflight == 0) m_err = 1;
                        else                 m_inflight--;
                    end
                end
            end
            @(posedge clock); #1;
            auto_in_d_ready = (id_mode == 2) || (id_mode == 1 && $urandom_range(1) == 1);
        end
    end

    // Continuous check of the outstanding count and the sticky flag.
    initial forever begin
        @(posedge clock); #2;
        if (!reset && chk_en) begin
            chk("inflight", 64'(inflight), 64'(m_inflight));
            chk("err_underflow", 64'(err_underflow), 64'(m_err));
        end
    end

    task automatic wait_drain(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clock);
            if (a_stim.size() == 0 && a_exp.size() == 0 && d_stim.size() == 0 &&
                d_exp.size() == 0 && m_inflight == 0) break;
        end
        if (k == budget) chk("drain_timeout", 64'(a_exp.size() + d_exp.size()), 64'(0));
    endtask

    task automatic wait_accepted(input int target, input int budget, input string name);
        int k;
        for (k = 0; k < budget && a_accepted < target; k++) @(posedge clock);
        chk(name, 64'(a_accepted), 64'(target));
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clock);
        #1 reset = 0; chk_en = 1;
        @(negedge clock);
        chk("rst_out_a_valid", 64'(auto_out_a_valid), 0);
        chk("rst_in_d_valid", 64'(auto_in_d_valid), 0);
        chk("rst_in_a_ready", 64'(auto_in_a_ready), 1);
        chk("rst_out_d_ready", 64'(auto_out_d_ready), 1);
        chk("rst_inflight", 64'(inflight), 0);

        // Single Get: one-cycle A latency, bank 1, fixed read data.
        fixed_en = 1; fixed_data = 32'hDEADBEEF;
        push_msg(3'd4, 2, 2'd1, 32'h8000_0040);
        wait_accepted(1, 20, "get_accept");
        @(negedge clock);
        chk("get_a_latency", 64'(auto_out_a_valid), 1);
        chk("get_bank", 64'(auto_out_a_bank), 1);
        wait_drain(50);
        chk("get_d_data", 64'(last_id_data), 64'h0DEADBEEF);
        fixed_en = 0;

        // A-FIFO backpressure.
        base = a_accepted; oa_mode = 0;
        for (int i = 0; i < 3; i++) push_msg(3'd0, 2, 2'(i), 32'($urandom));
        repeat (8) @(posedge clock);
        @(negedge clock);
        chk("bp_in_a_ready", 64'(auto_in_a_ready), 0);
        chk("bp_accepted", 64'(a_accepted - base), 2);
        oa_mode = 1;
        wait_drain(200);

        // Limiter: 5 Puts with responses withheld.
        base = a_accepted; oa_mode = 2; hold_resp = 1;
        for (int i = 0; i < 5; i++) push_msg(3'd0, 2, 2'(i), 32'($urandom));
        repeat (12) @(posedge clock);
        @(negedge clock);
        chk("lim_inflight", 64'(inflight), MAX_INF);
        chk("lim_in_a_ready", 64'(auto_in_a_ready), 0);
        chk("lim_accepted", 64'(a_accepted - base), 4);
        d_stim.push_back(d_hold.pop_front());
        wait_accepted(base + 5, 20, "lim_fifth_accept");
        // Burst started below MAX must complete once MAX is reached.
        d_stim.push_back(d_hold.pop_front());
        for (int k = 0; k < 30 && m_inflight != 3; k++) @(posedge clock);
        push_msg(3'd0, 3, 2'd3, 32'($urandom));
        wait_accepted(base + 7, 20, "burst_second_beat");
        @(negedge clock);
        chk("burst_inflight", 64'(inflight), MAX_INF);
        hold_resp = 0;
        while (d_hold.size() > 0) d_stim.push_back(d_hold.pop_front());
        wait_drain(300);

        // Multi-beat Get: only the final D beat retires it.
        push_msg(3'd4, 3, 2'd2, 32'($urandom));
        wait_drain(100);

        // Randomized traffic with random gaps and backpressure on both sides.
        gaps = 1; oa_mode = 1; id_mode = 1;
        for (int i = 0; i < 200; i++) begin
            int sel;
            sel = $urandom_range(2);
            push_msg(sel == 0 ? 3'd0 : sel == 1 ? 3'd1 : 3'd4, $urandom_range(3),
                     2'($urandom), 32'($urandom));
        end
        wait_drain(20000);
        gaps = 0; oa_mode = 2; id_mode = 2;

        // Spurious AccessAck with nothing outstanding.
        d_stim.push_back('{p: '{opcode: 3'd0, size: 3'd2, source: 2'd0, denied: 1'b0,
                                data: 32'h0, corrupt: 1'b0}, last: 1'b1});
        repeat (6) @(posedge clock);
        @(negedge clock);
        chk("uf_err", 64'(err_underflow), 1);
        chk("uf_inflight", 64'(inflight), 0);

        // Reset with both FIFOs holding two beats.
        base = a_accepted; oa_mode = 0; id_mode = 0;
        push_msg(3'd0, 2, 2'd0, 32'($urandom));
        push_msg(3'd0, 2, 2'd1, 32'($urandom));
        for (int i = 0; i < 2; i++)
            d_stim.push_back('{p: '{opcode: 3'd0, size: 3'd2, source: 2'(i), denied: 1'b0,
                                    data: 32'h0, corrupt: 1'b0}, last: 1'b1});
        for (int k = 0; k < 30 && !(a_accepted == base + 2 && d_exp.size() == 2); k++)
            @(posedge clock);
        chk("pre_rst_d_queued", 64'(d_exp.size()), 2);
        @(posedge clock); #1;
        reset = 1;
        a_exp.delete(); d_exp.delete(); m_inflight = 0; m_err = 0;
        @(posedge clock); #1;
        reset = 0;
        @(negedge clock);
        chk("mid_rst_out_a_valid", 64'(auto_out_a_valid), 0);
        chk("mid_rst_in_d_valid", 64'(auto_in_d_valid), 0);
        chk("mid_rst_inflight", 64'(inflight), 0);
        chk("mid_rst_err", 64'(err_underflow), 0);
        chk("mid_rst_in_a_ready", 64'(auto_in_a_ready), 1);
        repeat (3) @(posedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
